// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC synthesis stage.
// Contents: Q-format constants, register map addresses, pitch limits and
// reset values, the sequencer state enum, and a pitch clamping helper.
package lpc_pkg;

    localparam int Q_FRAC  = 12;
    localparam int ONE_Q12 = 4096;

    localparam logic [15:0] REG_PITCH  = 16'd0;
    localparam logic [15:0] REG_GAIN   = 16'd1;
    localparam logic [15:0] REG_STATUS = 16'd2;

    localparam logic [15:0] MIN_PITCH   = 16'd20;
    localparam logic [15:0] PITCH_RESET = 16'd80;
    localparam logic [15:0] GAIN_RESET  = 16'd1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Short pitch periods are raised to the minimum so a write can never
    // produce a pulse train faster than the filter can follow.
    function automatic logic [15:0] clamp_pitch(input logic [15:0] value);
        logic [15:0] result;
        if (value < MIN_PITCH) begin
            result = MIN_PITCH;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/lpc_excitation.sv
// Excitation generator for the LPC synthesis stage.
// On each start pulse it registers one excitation value e and advances its
// state: a pitch pulse train (voiced) or a +/-gain LFSR sign (unvoiced).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         one-cycle pulse at the start of a sample
//   voiced        voicing decision that applies to this sample
//   pitch_period  pulse spacing in samples (already clamped)
//   gain          signed excitation amplitude
//   e             excitation value registered on start, held until the next
module lpc_excitation
    import lpc_pkg::*;
#(
    parameter int          CW        = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 voiced,
    input  logic [15:0]          pitch_period,
    input  logic signed [CW-1:0] gain,
    output logic signed [CW-1:0] e
);

    logic [15:0]          cnt_r;
    logic [15:0]          cnt_next_s;
    logic [15:0]          lfsr_r;
    logic [15:0]          lfsr_next_s;
    logic                 lfsr_fb_s;
    logic signed [CW-1:0] e_r;
    logic signed [CW-1:0] e_next_s;

    // Next LFSR value, next pitch count and the excitation for this sample.
    always_comb begin
        // Fibonacci LFSR, taps 16,14,13,11.
        lfsr_fb_s   = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
        lfsr_next_s = {lfsr_r[14:0], lfsr_fb_s};

        if (cnt_r == 16'd0) begin
            cnt_next_s = pitch_period - 16'd1;
        end else begin
            cnt_next_s = cnt_r - 16'd1;
        end

        if (voiced) begin
            e_next_s = (cnt_r == 16'd0) ? gain : {CW{1'b0}};
        end else begin
            e_next_s = lfsr_r[15] ? -gain : gain;
        end
    end

    // Excitation state advances only when a sample actually starts.
    // The pitch counter only runs in voiced frames and is never reset by
    // a change of voicing, so pulse phase carries over between frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= 16'd0;
            lfsr_r <= LFSR_SEED;
            e_r    <= {CW{1'b0}};
        end else if (start) begin
            e_r    <= e_next_s;
            lfsr_r <= lfsr_next_s;
            if (voiced) begin
                cnt_r <= cnt_next_s;
            end
        end
    end

    assign e = e_r;

endmodule

// File: rtl/lpc_synth.sv
// LPC synthesis (decoder) stage.
// Runs a 10th-order all-pole IIR filter with one time-shared MAC, driven by
// the excitation from lpc_excitation, and emits one sample per sample_en.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   sample_en                     one-cycle pulse per output sample
//   coef_load, A1..A10, voiced    encoder frame parameters into shadow regs
//   y, y_valid                    synthesized sample and its update pulse
//   address/read/write/writedata  register port (pitch, gain, status)
//   readdata                      read data, valid the cycle after read
module lpc_synth
    import lpc_pkg::*;
#(
    parameter int          ORDER     = 10,
    parameter int          CW        = 16,
    parameter int          ACCW      = 40,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_en,
    input  logic                 coef_load,
    input  logic signed [CW-1:0] A1,
    input  logic signed [CW-1:0] A2,
    input  logic signed [CW-1:0] A3,
    input  logic signed [CW-1:0] A4,
    input  logic signed [CW-1:0] A5,
    input  logic signed [CW-1:0] A6,
    input  logic signed [CW-1:0] A7,
    input  logic signed [CW-1:0] A8,
    input  logic signed [CW-1:0] A9,
    input  logic signed [CW-1:0] A10,
    input  logic                 voiced,
    output logic signed [CW-1:0] y,
    output logic                 y_valid,
    input  logic [15:0]          address,
    input  logic                 read,
    input  logic                 write,
    input  logic [15:0]          writedata,
    output logic [15:0]          readdata
);

    localparam int IW = $clog2(ORDER);
    localparam int PW = 2 * CW;
    localparam logic signed [ACCW-1:0] SAT_MAX  = {{(ACCW-CW+1){1'b0}}, {(CW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN  = {{(ACCW-CW+1){1'b1}}, {(CW-1){1'b0}}};
    localparam logic signed [ACCW-1:0] RND_HALF = ACCW'(ONE_Q12 / 2);

    state_t               state_r;
    state_t               next_state_s;
    logic                 start_s;
    logic                 busy_s;
    logic                 overrun_evt_s;
    logic [IW-1:0]        idx_r;

    logic signed [CW-1:0] a_in_s   [ORDER];
    logic signed [CW-1:0] shadow_r [ORDER];
    logic signed [CW-1:0] active_r [ORDER];
    logic signed [CW-1:0] hist_r   [ORDER];
    logic                 shadow_voiced_r;
    logic                 start_voiced_s;

    logic signed [CW-1:0]   e_s;
    logic signed [CW-1:0]   a_sel_s;
    logic signed [CW-1:0]   h_sel_s;
    logic signed [PW-1:0]   prod_s;
    logic signed [ACCW-1:0] acc_r;
    logic signed [ACCW-1:0] e_scaled_s;
    logic signed [ACCW-1:0] acc_base_s;
    logic signed [ACCW-1:0] acc_next_s;
    logic signed [ACCW-1:0] rnd_s;
    logic signed [ACCW-1:0] shr_s;
    logic signed [CW-1:0]   sat_s;

    logic [15:0]          pitch_r;
    logic signed [CW-1:0] gain_r;
    logic                 overrun_r;
    logic signed [CW-1:0] y_r;
    logic                 y_valid_r;
    logic [15:0]          readdata_r;

    assign a_in_s[0] = A1;
    assign a_in_s[1] = A2;
    assign a_in_s[2] = A3;
    assign a_in_s[3] = A4;
    assign a_in_s[4] = A5;
    assign a_in_s[5] = A6;
    assign a_in_s[6] = A7;
    assign a_in_s[7] = A8;
    assign a_in_s[8] = A9;
    assign a_in_s[9] = A10;

    // A coef_load coinciding with sample_en must already apply to that sample.
    assign start_voiced_s = coef_load ? voiced : shadow_voiced_r;

    lpc_excitation #(
        .CW        (CW),
        .LFSR_SEED (LFSR_SEED)
    ) u_exc (
        .clk          (clk),
        .rst          (rst),
        .start        (start_s),
        .voiced       (start_voiced_s),
        .pitch_period (pitch_r),
        .gain         (gain_r),
        .e            (e_s)
    );

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a sample_en outside IDLE is dropped and flagged.
    always_comb begin
        next_state_s  = state_r;
        start_s       = 1'b0;
        busy_s        = (state_r != IDLE);
        overrun_evt_s = sample_en && (state_r != IDLE);
        case (state_r)
            IDLE: begin
                if (sample_en) begin
                    next_state_s = MAC;
                    start_s      = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            MAC: begin
                if (idx_r == IW'(ORDER - 1)) begin
                    next_state_s = OUT;
                end else begin
                    next_state_s = MAC;
                end
            end
            OUT:     next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // MAC operand select, accumulate, then round / shift / saturate.
    always_comb begin
        if (idx_r < IW'(ORDER)) begin
            a_sel_s = active_r[idx_r];
            h_sel_s = hist_r[idx_r];
        end else begin
            a_sel_s = {CW{1'b0}};
            h_sel_s = {CW{1'b0}};
        end
        prod_s = PW'(a_sel_s) * PW'(h_sel_s);

        // The first tap seeds the accumulator with e in Q12, so no separate
        // clear cycle is needed between samples.
        e_scaled_s = {{(ACCW-CW){e_s[CW-1]}}, e_s} <<< Q_FRAC;
        if (idx_r == {IW{1'b0}}) begin
            acc_base_s = e_scaled_s;
        end else begin
            acc_base_s = acc_r;
        end
        acc_next_s = acc_base_s - {{(ACCW-PW){prod_s[PW-1]}}, prod_s};

        rnd_s = acc_r + RND_HALF;
        shr_s = rnd_s >>> Q_FRAC;
        if (shr_s > SAT_MAX) begin
            sat_s = SAT_MAX[CW-1:0];
        end else if (shr_s < SAT_MIN) begin
            sat_s = SAT_MIN[CW-1:0];
        end else begin
            sat_s = shr_s[CW-1:0];
        end
    end

    // Shadow coefficient set, written by the encoder at any time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ORDER; i++) shadow_r[i] <= {CW{1'b0}};
            shadow_voiced_r <= 1'b0;
        end else if (coef_load) begin
            for (int i = 0; i < ORDER; i++) shadow_r[i] <= a_in_s[i];
            shadow_voiced_r <= voiced;
        end
    end

    // Filter datapath: coefficient swap at start, MAC taps, output and history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ORDER; i++) begin
                active_r[i] <= {CW{1'b0}};
                hist_r[i]   <= {CW{1'b0}};
            end
            idx_r     <= {IW{1'b0}};
            acc_r     <= {ACCW{1'b0}};
            y_r       <= {CW{1'b0}};
            y_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        idx_r <= {IW{1'b0}};
                        for (int i = 0; i < ORDER; i++) begin
                            active_r[i] <= coef_load ? a_in_s[i] : shadow_r[i];
                        end
                    end
                end
                MAC: begin
                    acc_r <= acc_next_s;
                    idx_r <= idx_r + IW'(1);
                end
                OUT: begin
                    y_r       <= sat_s;
                    hist_r[0] <= sat_s;
                    for (int i = 1; i < ORDER; i++) hist_r[i] <= hist_r[i-1];
                end
                default: begin
                    idx_r <= {IW{1'b0}};
                end
            endcase
            y_valid_r <= (state_r == OUT);
        end
    end

    // Register port: pitch, gain, sticky overrun and registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pitch_r    <= PITCH_RESET;
            gain_r     <= GAIN_RESET;
            overrun_r  <= 1'b0;
            readdata_r <= 16'd0;
        end else begin
            if (write && (address == REG_PITCH)) begin
                pitch_r <= clamp_pitch(writedata);
            end
            if (write && (address == REG_GAIN)) begin
                gain_r <= writedata;
            end
            // A new overrun takes priority over a clearing write.
            if (overrun_evt_s) begin
                overrun_r <= 1'b1;
            end else if (write && (address == REG_STATUS)) begin
                overrun_r <= 1'b0;
            end
            if (read) begin
                case (address)
                    REG_PITCH:  readdata_r <= pitch_r;
                    REG_GAIN:   readdata_r <= gain_r;
                    REG_STATUS: readdata_r <= {14'd0, busy_s, overrun_r};
                    default:    readdata_r <= 16'd0;
                endcase
            end
        end
    end

    assign y        = y_r;
    assign y_valid  = y_valid_r;
    assign readdata = readdata_r;

endmodule

// File: tb/tb_lpc_synth.sv
// Directed self-checking bench for lpc_synth.
module tb_lpc_synth;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               sample_en = 1'b0;
    logic               coef_load = 1'b0;
    logic signed [15:0] A1 = 16'sd0, A2 = 16'sd0, A3 = 16'sd0, A4 = 16'sd0, A5 = 16'sd0;
    logic signed [15:0] A6 = 16'sd0, A7 = 16'sd0, A8 = 16'sd0, A9 = 16'sd0, A10 = 16'sd0;
    logic               voiced = 1'b0;
    logic signed [15:0] y;
    logic               y_valid;
    logic [15:0]        address = 16'd0;
    logic               read = 1'b0;
    logic               write = 1'b0;
    logic [15:0]        writedata = 16'd0;
    logic [15:0]        readdata;

    int total = 0;
    int bad   = 0;

    lpc_synth dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .coef_load(coef_load),
        .A1(A1), .A2(A2), .A3(A3), .A4(A4), .A5(A5),
        .A6(A6), .A7(A7), .A8(A8), .A9(A9), .A10(A10),
        .voiced(voiced), .y(y), .y_valid(y_valid),
        .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic reg_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic reg_read(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk);
        address = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d = readdata;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One sample: returns y, the sample_en->y_valid gap, and whether the pulse
    // lasted exactly one cycle. lat stays -1 if y_valid never arrives.
    task automatic run_sample(input logic ld, output logic signed [15:0] yv,
                              output int lat, output logic one_cycle);
        @(negedge clk);
        sample_en = 1'b1; coef_load = ld;
        @(negedge clk);
        sample_en = 1'b0; coef_load = 1'b0;
        lat = -1; yv = 16'sd0; one_cycle = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (y_valid) begin
                lat = i;
                yv  = y;
                break;
            end
            @(negedge clk);
        end
        if (lat > 0) begin
            @(negedge clk);
            one_cycle = !y_valid;
        end
    endtask

    logic signed [15:0] yv;
    int                 lat;
    logic               one;
    logic [15:0]        rd;
    int                 pulses;
    int                 exp_t1 [5] = '{4096, 2048, 1024, 512, 256};
    int                 exp_uv [5] = '{-100, 100, -100, 100, -100};

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_y", y, 0);
        check("rst_y_valid", y_valid, 0);
        check("rst_readdata", readdata, 0);
        reg_read(16'd0, rd); check("rst_pitch", rd, 80);
        reg_read(16'd1, rd); check("rst_gain", rd, 1024);
        reg_read(16'd2, rd); check("rst_status", rd, 0);

        // Pulse train through a one-pole filter, A1=-0.5. A written pitch of 4
        // is raised to 20, so only the first of five samples carries a pulse:
        // 4096, then halving. Coefficients load in the same cycle as sample 1.
        reg_write(16'd0, 16'd4);
        reg_write(16'd1, 16'd4096);
        reg_read(16'd0, rd); check("t1_pitch_clamped", rd, 20);
        A1 = -16'sd2048; voiced = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_sample(i == 0, yv, lat, one);
            check($sformatf("t1_y%0d", i), yv, exp_t1[i]);
            check($sformatf("t1_lat%0d", i), lat, 12);
            check($sformatf("t1_pulse%0d", i), one, 1);
        end

        // Pitch clamp and unmapped address
        reg_write(16'd0, 16'd3);   reg_read(16'd0, rd); check("pitch3", rd, 20);
        reg_write(16'd0, 16'd100); reg_read(16'd0, rd); check("pitch100", rd, 100);
        reg_write(16'd7, 16'h1234); reg_read(16'd7, rd); check("addr7", rd, 0);
        reg_read(16'd0, rd); check("pitch_after_addr7", rd, 100);

        // Saturation: A1=-2.0, gain=32767 must clamp, never wrap negative
        pulse_reset();
        reg_write(16'd0, 16'd20);
        reg_write(16'd1, 16'd32767);
        A1 = -16'sd8192; voiced = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_sample(i == 0, yv, lat, one);
            check($sformatf("sat_y%0d", i), yv, 32767);
        end

        // Overrun: second sample_en 5 cycles after the first is dropped
        @(negedge clk);
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        pulses = 0;
        rd = 16'hFFFF;
        for (int n = 1; n <= 30; n++) begin
            if (y_valid) pulses++;
            case (n)
                5: sample_en = 1'b1;
                6: begin sample_en = 1'b0; address = 16'd2; read = 1'b1; end
                7: begin read = 1'b0; rd = readdata; end
                default: ;
            endcase
            @(negedge clk);
        end
        check("ovr_status_busy", rd, 16'h0003);
        check("ovr_one_pulse", pulses, 1);
        reg_read(16'd2, rd); check("ovr_sticky", rd, 16'h0001);
        reg_write(16'd2, 16'd0);
        reg_read(16'd2, rd); check("ovr_cleared", rd, 16'h0000);

        // Unvoiced, all A=0: y=+/-gain with sign from LFSR[15] starting at ACE1
        pulse_reset();
        A1 = 16'sd0; voiced = 1'b0;
        reg_write(16'd1, 16'd100);
        for (int i = 0; i < 5; i++) begin
            run_sample(i == 0, yv, lat, one);
            check($sformatf("uv_y%0d", i), yv, exp_uv[i]);
        end

        // Reset in the middle of MAC: no y_valid, y back to 0, LFSR reseeded
        @(negedge clk);
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_y", y, 0);
        pulses = 0;
        for (int n = 0; n < 20; n++) begin
            if (y_valid) pulses++;
            @(negedge clk);
        end
        check("midrst_no_valid", pulses, 0);
        run_sample(1'b0, yv, lat, one);
        check("midrst_reseed_y", yv, -1024);
        check("midrst_reseed_lat", lat, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
